// File: rtl/oled_spi_if.sv
// Host/panel-side signal bundle for oled_spi_ctrl: byte-push handshake, SPI link and panel power/reset pins.
interface oled_spi_if;
   logic [7:0] data_in;
   logic       write_enable;
   logic       buffer_full;
   logic       init_done;
   logic       spi_cs;
   logic       spi_clk;
   logic       spi_mosi;
   logic       oled_dc;
   logic       oled_res;
   logic       oled_vbat;
   logic       oled_vdd;

   modport master (
      output data_in, write_enable,
      input  buffer_full, init_done, spi_cs, spi_clk, spi_mosi,
             oled_dc, oled_res, oled_vbat, oled_vdd
   );

   modport slave (
      input  data_in, write_enable,
      output buffer_full, init_done, spi_cs, spi_clk, spi_mosi,
             oled_dc, oled_res, oled_vbat, oled_vdd
   );
endinterface

// File: rtl/oled_spi_ctrl.sv
// PmodOLED-style power-up sequencer, host byte FIFO and write-only SPI mode-0 serializer.
// Panel control pins are registered from the sequencer state, so they follow state changes by one cycle.
module oled_spi_ctrl #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RES_CYCLES = 1000,
   parameter int unsigned PWR_WAIT   = 10000
) (
   input  logic      clk,
   input  logic      rst_n,
   oled_spi_if.slave bus
);

   localparam int unsigned WAIT_MAX = (PWR_WAIT > RES_CYCLES) ? PWR_WAIT : RES_CYCLES;
   localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
   localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W   = PTR_W + 1;

   typedef enum logic [2:0] {
      ST_VDD_WAIT,
      ST_RES_LO,
      ST_RES_HI,
      ST_INIT,
      ST_VBAT_WAIT,
      ST_DISP_ON,
      ST_READY
   } seq_e;

   typedef enum logic [1:0] {
      SER_IDLE,
      SER_SHIFT,
      SER_GAP
   } ser_e;

   // Sequencer state
   seq_e             seq_q, seq_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       cmd_idx_q, cmd_idx_d;
   logic             vdd_q, vdd_d;
   logic             vbat_q, vbat_d;
   logic             res_q, res_d;
   logic             init_done_q, init_done_d;

   // Serializer state
   ser_e             ser_q, ser_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [3:0]       edge_q, edge_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             cs_q, cs_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             dc_q, dc_d;

   // Host byte FIFO
   logic [7:0]        mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0] count_q, count_d;

   logic       full_c;
   logic       empty_c;
   logic       push_c;
   logic       pop_c;
   logic       div_last_c;
   logic       ser_ready_c;
   logic       ser_done_c;
   logic       ser_start_c;
   logic [7:0] ser_byte_c;
   logic       ser_dc_c;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd0:    return 8'hAE;
         3'd1:    return 8'h8D;
         3'd2:    return 8'h14;
         default: return 8'hAF;
      endcase
   endfunction

   assign full_c      = (count_q == FCNT_W'(FIFO_DEPTH));
   assign empty_c     = (count_q == '0);
   assign push_c      = bus.write_enable && !full_c;
   assign div_last_c  = (div_q == DIV_W'(CLK_DIV - 1));
   // A new byte may load once the CS-high gap has lasted CLK_DIV cycles
   assign ser_ready_c = (ser_q == SER_IDLE) || ((ser_q == SER_GAP) && div_last_c);
   assign ser_done_c  = (ser_q == SER_SHIFT) && div_last_c && sclk_q && (edge_q == 4'd15);

   // Power-up sequencer and byte source selection
   always_comb begin
      seq_d       = seq_q;
      cnt_d       = cnt_q;
      cmd_idx_d   = cmd_idx_q;
      ser_start_c = 1'b0;
      ser_byte_c  = 8'h00;
      ser_dc_c    = 1'b0;
      pop_c       = 1'b0;

      case (seq_q)
         ST_VDD_WAIT: begin
            if (cnt_q == CNT_W'(PWR_WAIT - 1)) begin
               seq_d = ST_RES_LO;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RES_LO: begin
            if (cnt_q == CNT_W'(RES_CYCLES - 1)) begin
               seq_d = ST_RES_HI;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RES_HI: begin
            if (cnt_q == CNT_W'(RES_CYCLES - 1)) begin
               seq_d = ST_INIT;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_INIT: begin
            if (ser_ready_c && (cmd_idx_q < 3'd3)) begin
               ser_start_c = 1'b1;
               ser_byte_c  = init_cmd(cmd_idx_q);
               cmd_idx_d   = cmd_idx_q + 3'd1;
            end
            if (ser_done_c && (cmd_idx_q == 3'd3)) begin
               seq_d = ST_VBAT_WAIT;
            end
         end
         ST_VBAT_WAIT: begin
            if (cnt_q == CNT_W'(PWR_WAIT - 1)) begin
               seq_d = ST_DISP_ON;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DISP_ON: begin
            if (ser_ready_c && (cmd_idx_q == 3'd3)) begin
               ser_start_c = 1'b1;
               ser_byte_c  = init_cmd(cmd_idx_q);
               cmd_idx_d   = 3'd4;
            end
            if (ser_done_c && (cmd_idx_q == 3'd4)) begin
               seq_d = ST_READY;
            end
         end
         ST_READY: begin
            if (ser_ready_c && !empty_c) begin
               ser_start_c = 1'b1;
               ser_byte_c  = mem_q[rd_ptr_q];
               ser_dc_c    = 1'b1;
               pop_c       = 1'b1;
            end
         end
         default: begin
            seq_d = ST_VDD_WAIT;
            cnt_d = '0;
         end
      endcase

      // Supplies latch on and stay on; reset is low only while in RES_LO
      vdd_d       = 1'b0;
      vbat_d      = vbat_q & (seq_q != ST_VBAT_WAIT);
      res_d       = (seq_q != ST_RES_LO);
      init_done_d = init_done_q | (seq_q == ST_READY);
   end

   // Mode-0 serializer: each half-period is CLK_DIV cycles, 16 half-periods per byte
   always_comb begin
      ser_d   = ser_q;
      div_d   = div_q;
      edge_d  = edge_q;
      shreg_d = shreg_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      dc_d    = dc_q;

      case (ser_q)
         SER_SHIFT: begin
            if (div_last_c) begin
               div_d  = '0;
               edge_d = edge_q + 4'd1;
               sclk_d = ~sclk_q;
               if (sclk_q) begin
                  if (edge_q == 4'd15) begin
                     ser_d  = SER_GAP;
                     cs_d   = 1'b1;
                     mosi_d = 1'b0;
                  end else begin
                     mosi_d  = shreg_q[7];
                     shreg_d = {shreg_q[6:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         SER_GAP: begin
            if (div_last_c) begin
               ser_d = SER_IDLE;
               div_d = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: ;
      endcase

      if (ser_start_c) begin
         ser_d   = SER_SHIFT;
         div_d   = '0;
         edge_d  = 4'd0;
         cs_d    = 1'b0;
         sclk_d  = 1'b0;
         mosi_d  = ser_byte_c[7];
         shreg_d = {ser_byte_c[6:0], 1'b0};
         dc_d    = ser_dc_c;
      end
   end

   // FIFO pointer and occupancy update; a push is refused whenever full
   always_comb begin
      wr_ptr_d = push_c ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d = pop_c  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      count_d  = count_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seq_q       <= ST_VDD_WAIT;
         cnt_q       <= '0;
         cmd_idx_q   <= 3'd0;
         vdd_q       <= 1'b1;
         vbat_q      <= 1'b1;
         res_q       <= 1'b1;
         init_done_q <= 1'b0;
         ser_q       <= SER_IDLE;
         div_q       <= '0;
         edge_q      <= 4'd0;
         shreg_q     <= 8'h00;
         cs_q        <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         dc_q        <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         seq_q       <= seq_d;
         cnt_q       <= cnt_d;
         cmd_idx_q   <= cmd_idx_d;
         vdd_q       <= vdd_d;
         vbat_q      <= vbat_d;
         res_q       <= res_d;
         init_done_q <= init_done_d;
         ser_q       <= ser_d;
         div_q       <= div_d;
         edge_q      <= edge_d;
         shreg_q     <= shreg_d;
         cs_q        <= cs_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         dc_q        <= dc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (rst_n && push_c) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   assign bus.buffer_full = full_c;
   assign bus.init_done   = init_done_q;
   assign bus.spi_cs      = cs_q;
   assign bus.spi_clk     = sclk_q;
   assign bus.spi_mosi    = mosi_q;
   assign bus.oled_dc     = dc_q;
   assign bus.oled_res    = res_q;
   assign bus.oled_vbat   = vbat_q;
   assign bus.oled_vdd    = vdd_q;

endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Self-checking bench for oled_spi_ctrl: queue-level FIFO model, SPI frame decoder and power-up timeline rules.
module tb_oled_spi_ctrl;

   localparam int CD    = 2;
   localparam int DEPTH = 4;
   localparam int RES   = 8;
   localparam int PWR   = 16;
   localparam logic [7:0] CMDS [4] = '{8'hAE, 8'h8D, 8'h14, 8'hAF};

   logic clk = 1'b0;
   logic rst_n;

   oled_spi_if bus ();

   oled_spi_ctrl #(
      .CLK_DIV   (CD),
      .FIFO_DEPTH(DEPTH),
      .RES_CYCLES(RES),
      .PWR_WAIT  (PWR)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model state
   logic [7:0] mq [$];
   int  cyc = 0;
   bit  rst_seen = 1'b0;
   int  accepted = 0;

   // Frame decoder state
   bit         prev_cs = 1'b1;
   bit         prev_sclk = 1'b0;
   bit         in_frame = 1'b0;
   bit         fr_dc = 1'b0;
   int         fr_bits = 0;
   int         fr_len = 0;
   int         fr_idx = 0;
   logic [7:0] fr_byte = 8'h00;
   logic [7:0] fr_exp = 8'h00;
   int         last_rise = -1000;
   int         cmd_cnt = 0;
   int         cmd_start [4];
   int         cmd_end [4];
   int         done_rise = 0;
   int         data_frames = 0;
   logic [7:0] last_data = 8'h00;

   // Cycle numbering restarts with each reset; pushes are modelled at the sampling edge
   always @(posedge clk) begin
      if (!rst_n) begin
         cyc = 0;
         rst_seen = 1'b1;
         mq.delete();
      end else begin
         cyc++;
         rst_seen = 1'b0;
         if (bus.write_enable && (mq.size() < DEPTH)) begin
            mq.push_back(bus.data_in);
            accepted++;
         end
      end
   end

   // Compare process: runs every cycle on the falling edge
   always @(negedge clk) begin
      if (rst_seen) begin
         check("reset_outputs",
               {bus.spi_cs, bus.spi_clk, bus.spi_mosi, bus.oled_dc, bus.oled_res,
                bus.oled_vbat, bus.oled_vdd, bus.init_done, bus.buffer_full}, 9'b100011100);
         in_frame  = 1'b0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b0;
         last_rise = -1000;
         cmd_cnt   = 0;
         done_rise = 0;
         for (int k = 0; k < 4; k++) begin
            cmd_start[k] = 0;
            cmd_end[k]   = 0;
         end
      end else begin
         check("oled_vdd", bus.oled_vdd, 1'b0);
         check("oled_res", bus.oled_res, !(cyc >= 1 + PWR && cyc < 1 + PWR + RES));
         check("oled_vbat", bus.oled_vbat, !(cmd_end[2] != 0 && cyc >= cmd_end[2] + 1));
         check("init_done", bus.init_done, (cmd_end[3] != 0 && cyc >= cmd_end[3] + 1));
         if (bus.init_done && done_rise == 0) done_rise = cyc;

         if (prev_cs && !bus.spi_cs) begin
            in_frame = 1'b1;
            fr_dc    = bus.oled_dc;
            fr_bits  = 0;
            fr_len   = 0;
            fr_byte  = 8'h00;
            check("cs_gap", (cyc - last_rise) >= CD, 1'b1);
            if (!bus.oled_dc) begin
               check("cmd_count", cmd_cnt < 4, 1'b1);
               fr_idx = cmd_cnt;
               if (cmd_cnt < 4) begin
                  fr_exp = CMDS[cmd_cnt];
                  check("cmd_start_cycle", cyc,
                        (cmd_cnt < 3) ? (1 + PWR + 2 * RES + cmd_cnt * 17 * CD)
                                      : (cmd_end[2] + 1 + PWR));
                  cmd_start[cmd_cnt] = cyc;
               end
               cmd_cnt++;
            end else begin
               check("data_after_init", bus.init_done, 1'b1);
               check("data_has_source", mq.size() != 0, 1'b1);
               fr_exp = (mq.size() != 0) ? mq.pop_front() : 8'h00;
            end
         end

         if (in_frame) begin
            if (!bus.spi_cs) begin
               fr_len++;
               check("dc_stable", bus.oled_dc, fr_dc);
               if (!prev_sclk && bus.spi_clk) begin
                  fr_byte = {fr_byte[6:0], bus.spi_mosi};
                  fr_bits++;
               end
            end else begin
               in_frame  = 1'b0;
               last_rise = cyc;
               check("frame_len", fr_len, 16 * CD);
               check("frame_bits", fr_bits, 8);
               check(fr_dc ? "data_byte" : "cmd_byte", fr_byte, fr_exp);
               if (!fr_dc && fr_idx < 4) cmd_end[fr_idx] = cyc;
               if (fr_dc) begin
                  data_frames++;
                  last_data = fr_byte;
               end
            end
         end

         if (bus.spi_cs) check("idle_lines", {bus.spi_clk, bus.spi_mosi}, 2'b00);
         check("buffer_full", bus.buffer_full, mq.size() == DEPTH);
         prev_cs   = bus.spi_cs;
         prev_sclk = bus.spi_clk;
      end
   end

   task automatic drive_push(input logic [7:0] b);
      @(negedge clk);
      bus.write_enable = 1'b1;
      bus.data_in      = b;
   endtask

   task automatic end_push();
      @(negedge clk);
      bus.write_enable = 1'b0;
   endtask

   task automatic wait_init();
      int n = 0;
      while (!bus.init_done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("init_timeout", bus.init_done, 1'b1);
   endtask

   task automatic wait_drain();
      int idle = 0;
      int n = 0;
      while (idle < 6 && n < 6000) begin
         @(negedge clk);
         #1;
         n++;
         if (mq.size() == 0 && !in_frame && bus.spi_cs) idle++;
         else idle = 0;
      end
      check("drain_timeout", idle >= 6, 1'b1);
   endtask

   task automatic check_timeline();
      check("t_first_cmd", cmd_start[0], 33);
      check("t_third_cmd_end", cmd_end[2], 133);
      check("t_disp_on", cmd_start[3], 150);
      check("t_init_done", done_rise, 183);
   endtask

   logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
   int acc0;
   int df0;
   int n;

   initial begin
      rst_n            = 1'b0;
      bus.write_enable = 1'b0;
      bus.data_in      = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Six pushes during power-up: only four fit
      acc0 = accepted;
      df0  = data_frames;
      for (int i = 0; i < 5; i++) drive_push(hello[i]);
      drive_push(8'h21);
      end_push();
      #1;
      check("full_after_overflow", bus.buffer_full, 1'b1);
      check("powerup_accepted", accepted - acc0, 4);
      wait_init();
      check_timeline();
      wait_drain();
      check("powerup_frames", data_frames - df0, 4);
      check("powerup_last", last_data, 8'h6C);

      // "hello" pushed on consecutive cycles in READY
      acc0 = accepted;
      df0  = data_frames;
      for (int i = 0; i < 5; i++) drive_push(hello[i]);
      end_push();
      wait_drain();
      check("hello_frames", data_frames - df0, accepted - acc0);
      check("hello_last", last_data, 8'h6F);

      // Single byte
      drive_push(8'hA5);
      end_push();
      wait_drain();
      check("a5_byte", last_data, 8'hA5);

      // Push coinciding with a pop at count 3, across the pointer wrap
      for (int i = 0; i < 4; i++) drive_push(8'hC1 + 8'(i));
      end_push();
      n = 0;
      while (!bus.spi_cs && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      repeat (CD - 1) @(negedge clk);
      bus.write_enable = 1'b1;
      bus.data_in      = 8'hC5;
      @(negedge clk);
      #1;
      check("pushpop_not_full", bus.buffer_full, 1'b0);
      check("pushpop_model_count", mq.size(), 3);
      bus.data_in = 8'hC6;
      @(negedge clk);
      #1;
      check("pushpop_then_full", bus.buffer_full, 1'b1);
      bus.write_enable = 1'b0;
      wait_drain();
      check("pushpop_last", last_data, 8'hC6);

      // Randomized bursts with idle gaps
      for (int i = 0; i < 50; i++) begin
         repeat ($urandom_range(0, 45)) @(negedge clk);
         for (int j = 0; j < int'($urandom_range(1, 4)); j++) drive_push(8'($urandom));
         end_push();
      end
      wait_drain();

      // Reset in the middle of a data byte (while bit 3 is on the wire)
      drive_push(8'h3C);
      drive_push(8'h5A);
      drive_push(8'h96);
      end_push();
      n = 0;
      while (!(in_frame && fr_dc && fr_bits == 5) && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("reached_bit3", fr_bits, 5);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      df0 = data_frames;
      drive_push(8'h11);
      drive_push(8'h22);
      end_push();
      wait_init();
      check_timeline();
      wait_drain();
      check("post_reset_frames", data_frames - df0, 2);
      check("post_reset_last", last_data, 8'h22);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
